// File: rtl/demux2_reg8_pkg.sv
// Shared definitions for the registered 1:2 demultiplexer: data width,
// channel identifiers and the ping-pong steering state encodings.
package demux_defs;

    localparam int WIDTH = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam logic TO_A = 1'b0;
    localparam logic TO_B = 1'b1;

endpackage

// File: rtl/demux2_reg8_if.sv
// Producer/consumer bundle of the demultiplexer; the master side drives data,
// steering and acks, the slave side (the demux itself) returns ready and channels.
interface demux2_reg8_if
    import demux_defs::*;
#(
    parameter int W = WIDTH
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         sel;
    logic         auto;
    logic         next;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         a_valid;
    logic         b_valid;
    logic         a_ack;
    logic         b_ack;

    modport master (
        output din, din_valid, sel, auto, a_ack, b_ack,
        input  din_ready, next, out_a, out_b, a_valid, b_valid
    );

    modport slave (
        input  din, din_valid, sel, auto, a_ack, b_ack,
        output din_ready, next, out_a, out_b, a_valid, b_valid
    );
endinterface

// File: rtl/demux_slot.sv
// One output channel: holding register, valid flag and ready term.
// A load wins over an ack, so a full channel being acked can be refilled.
module demux_slot
    import demux_defs::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ack,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         ready
);

    assign ready = !valid || ack;

    // The data register is never cleared by an ack; it keeps the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
        end else if (ack && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux2_reg8.sv
// Registered 1:2 demultiplexer: steers each accepted word into channel A or B,
// either by explicit select or by an alternating destination register.
module demux2_reg8
    import demux_defs::*;
(
    input logic clk,
    input logic rst_n,
    demux2_reg8_if.slave bus
);

    logic             nxt;
    logic             dest;
    logic             accept;
    logic             ready_a;
    logic             ready_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             valid_a;
    logic             valid_b;

    assign dest          = bus.auto ? nxt : bus.sel;
    assign bus.din_ready = (dest == CH_B) ? ready_b : ready_a;
    assign accept        = bus.din_valid && bus.din_ready;

    demux_slot #(.W(WIDTH)) u_slot_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && (dest == CH_A)),
        .din   (bus.din),
        .ack   (bus.a_ack),
        .data  (data_a),
        .valid (valid_a),
        .ready (ready_a)
    );

    demux_slot #(.W(WIDTH)) u_slot_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && (dest == CH_B)),
        .din   (bus.din),
        .ack   (bus.b_ack),
        .data  (data_b),
        .valid (valid_b),
        .ready (ready_b)
    );

    // Ping-pong pointer only advances on accepts made in auto mode, so it
    // resumes where it left off when auto steering is re-enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt <= TO_A;
        end else if (accept && bus.auto) begin
            nxt <= (nxt == TO_A) ? TO_B : TO_A;
        end
    end

    assign bus.next    = nxt;
    assign bus.out_a   = data_a;
    assign bus.out_b   = data_b;
    assign bus.a_valid = valid_a;
    assign bus.b_valid = valid_b;

endmodule

// File: tb/tb_demux2_reg8.sv
// Self-checking bench for demux2_reg8: directed scenarios plus a randomized run
// compared against an array-based reference model of the channels.
module tb_demux2_reg8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] m_out[2];
    logic       m_val[2];
    logic       m_next;

    demux2_reg8_if #(.W(8)) bus ();

    demux2_reg8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_dest();
        return bus.auto ? m_next : bus.sel;
    endfunction

    function automatic logic m_ready();
        logic d;
        logic [1:0] acks;
        d    = m_dest();
        acks = {bus.b_ack, bus.a_ack};
        return !m_val[d] || acks[d];
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic d;
        logic acc;
        logic [1:0] acks;
        d    = m_dest();
        acc  = bus.din_valid && m_ready();
        acks = {bus.b_ack, bus.a_ack};
        for (int x = 0; x < 2; x++) begin
            if (acc && d == x[0]) begin
                m_out[x] = bus.din;
                m_val[x] = 1'b1;
            end else if (acks[x] && m_val[x]) begin
                m_val[x] = 1'b0;
            end
        end
        if (acc && bus.auto) m_next = ~m_next;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        bus.sel       = 1'b0;
        bus.auto      = 1'b0;
        bus.a_ack     = 1'b0;
        bus.b_ack     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_val[0] = 1'b0;  m_val[1] = 1'b0;
        m_next   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.din = 8'h5A; bus.din_valid = 1'b1; bus.auto = 1'b1;
        tick();
        bus.din = 8'hC3;
        tick();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_val[0] = 1'b0;  m_val[1] = 1'b0;
        m_next   = 1'b0;
        #1;
        checks++;
        if (bus.out_a !== 8'h00 || bus.out_b !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_outs out_a=%h out_b=%h expected 00/00", bus.out_a, bus.out_b);
        end
        checks++;
        if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.next !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags a_valid=%b b_valid=%b next=%b expected 0/0/0",
                     bus.a_valid, bus.b_valid, bus.next);
        end
        checks++;
        if (bus.din_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready din_ready=%b expected 1", bus.din_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.auto = 1'b1; bus.din = 8'h77; bus.din_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.out_a !== 8'h77 || bus.a_valid !== 1'b1 || bus.b_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_first_to_a out_a=%h a_valid=%b b_valid=%b expected 77/1/0",
                     bus.out_a, bus.a_valid, bus.b_valid);
        end
    endtask

    task automatic test_explicit();
        do_reset();
        bus.sel = 1'b1; bus.din = 8'hA5; bus.din_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.out_b !== 8'hA5 || bus.b_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL explicit_b out_b=%h b_valid=%b expected a5/1", bus.out_b, bus.b_valid);
        end
        checks++;
        if (bus.out_a !== 8'h00 || bus.a_valid !== 1'b0 || bus.next !== 1'b0) begin
            failures++;
            $display("[TB] FAIL explicit_a_untouched out_a=%h a_valid=%b next=%b expected 00/0/0",
                     bus.out_a, bus.a_valid, bus.next);
        end
    endtask

    task automatic test_pingpong();
        logic [7:0] exp_a[4];
        logic [7:0] exp_b[4];
        exp_a = '{8'h01, 8'h01, 8'h03, 8'h03};
        exp_b = '{8'h00, 8'h02, 8'h02, 8'h04};
        do_reset();
        bus.auto = 1'b1; bus.a_ack = 1'b1; bus.b_ack = 1'b1; bus.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = 8'(i + 1);
            #1;
            checks++;
            if (bus.din_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL pingpong_ready[%0d] din_ready=%b expected 1", i, bus.din_ready);
            end
            tick();
            checks++;
            if (bus.out_a !== exp_a[i] || bus.out_b !== exp_b[i] || bus.next !== 1'((i + 1) % 2)) begin
                failures++;
                $display("[TB] FAIL pingpong[%0d] out_a=%h out_b=%h next=%b expected %h/%h/%0d",
                         i, bus.out_a, bus.out_b, bus.next, exp_a[i], exp_b[i], (i + 1) % 2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.din = 8'h11; bus.din_valid = 1'b1;
        tick();
        bus.din = 8'h22;
        #1;
        checks++;
        if (bus.din_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_stall_ready din_ready=%b expected 0", bus.din_ready);
        end
        tick();
        checks++;
        if (bus.out_a !== 8'h11 || bus.a_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_hold out_a=%h a_valid=%b expected 11/1", bus.out_a, bus.a_valid);
        end
        bus.a_ack = 1'b1;
        #1;
        checks++;
        if (bus.din_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_ack_ready din_ready=%b expected 1", bus.din_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.out_a !== 8'h22 || bus.a_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_refill out_a=%h a_valid=%b expected 22/1", bus.out_a, bus.a_valid);
        end
    endtask

    task automatic test_acks();
        do_reset();
        bus.a_ack = 1'b1;
        tick();
        checks++;
        if (bus.a_valid !== 1'b0 || bus.out_a !== 8'h00 || bus.b_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stray_ack a_valid=%b out_a=%h b_valid=%b expected 0/00/0",
                     bus.a_valid, bus.out_a, bus.b_valid);
        end
        idle_inputs();
        bus.din = 8'h33; bus.din_valid = 1'b1;
        tick();
        bus.din = 8'h44; bus.sel = 1'b1;
        tick();
        bus.din = 8'h99; bus.sel = 1'b0;
        #1;
        checks++;
        if (bus.din_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_stall_a din_ready=%b expected 0", bus.din_ready);
        end
        bus.sel = 1'b1;
        #1;
        checks++;
        if (bus.din_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_stall_b din_ready=%b expected 0", bus.din_ready);
        end
        idle_inputs();
        bus.a_ack = 1'b1; bus.b_ack = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 || bus.out_a !== 8'h33 || bus.out_b !== 8'h44) begin
            failures++;
            $display("[TB] FAIL dual_ack a_valid=%b b_valid=%b out_a=%h out_b=%h expected 0/0/33/44",
                     bus.a_valid, bus.b_valid, bus.out_a, bus.out_b);
        end
    endtask

    task automatic test_auto_toggle();
        do_reset();
        bus.auto = 1'b1; bus.din = 8'h55; bus.din_valid = 1'b1;
        tick();
        checks++;
        if (bus.next !== 1'b1 || bus.out_a !== 8'h55) begin
            failures++;
            $display("[TB] FAIL auto_first next=%b out_a=%h expected 1/55", bus.next, bus.out_a);
        end
        bus.auto = 1'b0; bus.sel = 1'b0; bus.a_ack = 1'b1; bus.din = 8'h66;
        tick();
        bus.din = 8'h77;
        tick();
        checks++;
        if (bus.next !== 1'b1 || bus.out_a !== 8'h77 || bus.b_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL auto_hold next=%b out_a=%h b_valid=%b expected 1/77/0",
                     bus.next, bus.out_a, bus.b_valid);
        end
        bus.a_ack = 1'b0; bus.auto = 1'b1; bus.din = 8'h88;
        tick();
        idle_inputs();
        checks++;
        if (bus.out_b !== 8'h88 || bus.b_valid !== 1'b1 || bus.next !== 1'b0) begin
            failures++;
            $display("[TB] FAIL auto_resume out_b=%h b_valid=%b next=%b expected 88/1/0",
                     bus.out_b, bus.b_valid, bus.next);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bus.din       = 8'($urandom);
            bus.din_valid = ($urandom_range(0, 3) != 0);
            bus.sel       = 1'($urandom);
            bus.auto      = ($urandom_range(0, 2) != 0);
            bus.a_ack     = 1'($urandom);
            bus.b_ack     = 1'($urandom);
            #1;
            checks++;
            if (bus.din_ready !== m_ready()) begin
                failures++;
                $display("[TB] FAIL rand_ready[%0d] din_ready=%b expected %b", i, bus.din_ready, m_ready());
            end
            tick();
            checks++;
            if (bus.out_a !== m_out[0] || bus.out_b !== m_out[1] || bus.a_valid !== m_val[0] ||
                bus.b_valid !== m_val[1] || bus.next !== m_next) begin
                failures++;
                $display("[TB] FAIL rand_state[%0d] got a=%h/%b b=%h/%b next=%b expected a=%h/%b b=%h/%b next=%b",
                         i, bus.out_a, bus.a_valid, bus.out_b, bus.b_valid, bus.next,
                         m_out[0], m_val[0], m_out[1], m_val[1], m_next);
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_val[0] = 1'b0;  m_val[1] = 1'b0;
        m_next   = 1'b0;
        idle_inputs();
        do_reset();
        test_reset();
        test_explicit();
        test_pingpong();
        test_backpressure();
        test_acks();
        test_auto_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
